poly_sub_seq: RTL and testbench

Sequencer that computes a full ML-KEM polynomial difference c = a − b mod q (q = 3329), coefficient-wise over N_COEFF entries, using the shared `mod_sub` pipeline. It reads operand coefficients from two synchronous-read polynomial RAMs, issues them to `mod_sub` at one pair per cycle, and writes results to a destination RAM. It also reports completion and sticky protocol errors. It sits between the poly-arith top-level command decoder and the `mod_sub` unit.

---
 rtl/poly_sub_seq.sv | 114 +++++++++++
 tb/tb_poly_sub_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/poly_sub_seq.sv
// poly_sub_seq: streams c = a - b mod q over a polynomial through the shared mod_sub
// pipeline. Operands are read from the A/B RAMs and results are written to the
// destination RAM.
module poly_sub_seq #(
  parameter int unsigned N_COEFF = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned SUB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [11:0]       a_rd_data_i,
  input  logic [11:0]       b_rd_data_i,
  output logic [11:0]       sub_op1_o,
  output logic [11:0]       sub_op2_o,
  output logic              sub_valid_o,
  input  logic [11:0]       sub_result_i,
  input  logic              sub_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned OUT_W = $clog2(SUB_LAT + 2) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, wr_cnt_q, wr_cnt_nxt;
  logic [OUT_W-1:0] outstanding_q;
  logic             sub_valid_q;
  logic             err_q;
  logic             rd_en_c, wr_en_c, stray_c, launch_c;

  // Read and write strobes, plus the stray-result condition.
  always_comb begin
    rd_en_c    = (state_q == S_ISSUE) && !hold_i;
    wr_en_c    = sub_valid_i && (outstanding_q != '0);
    stray_c    = sub_valid_i && (outstanding_q == '0);
    launch_c   = (state_q == S_IDLE) && start_i;
    wr_cnt_nxt = wr_cnt_q + CNT_W'(wr_en_c);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. DRAIN looks ahead at the post-write count so that done
  // lands on the cycle after the last write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISSUE;
      S_ISSUE: if (rd_en_c && (issue_cnt_q == CNT_W'(N_COEFF - 1))) state_d = S_DRAIN;
      S_DRAIN: if (wr_cnt_nxt == CNT_W'(N_COEFF)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue/write/outstanding counters, operand-valid stage and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q   <= '0;
      wr_cnt_q      <= '0;
      outstanding_q <= '0;
      sub_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      sub_valid_q   <= rd_en_c;
      outstanding_q <= outstanding_q + OUT_W'(sub_valid_q) - OUT_W'(wr_en_c);
      if (launch_c) begin
        issue_cnt_q <= '0;
        wr_cnt_q    <= '0;
      end else begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(rd_en_c);
        wr_cnt_q    <= wr_cnt_nxt;
      end
      if (launch_c)     err_q <= 1'b0;
      else if (stray_c) err_q <= 1'b1;
    end
  end

  // Outputs are decoded from registered state. The data paths are gated so
  // every output sits at 0 while the block is in reset.
  always_comb begin
    busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done_o      = (state_q == S_DONE);
    err_o       = err_q;
    rd_en_o     = rd_en_c;
    rd_addr_o   = issue_cnt_q[ADDR_W-1:0];
    sub_valid_o = sub_valid_q;
    sub_op1_o   = sub_valid_q ? a_rd_data_i : 12'd0;
    sub_op2_o   = sub_valid_q ? b_rd_data_i : 12'd0;
    wr_en_o     = wr_en_c;
    wr_addr_o   = wr_cnt_q[ADDR_W-1:0];
    wr_data_o   = wr_en_c ? sub_result_i : 12'd0;
  end

endmodule

// File: tb/tb_poly_sub_seq.sv
// Bench for poly_sub_seq: RAM and mod_sub models, with a scoreboard of expected writes.
module tb_poly_sub_seq;

  localparam int N = 256;
  localparam int Q = 3329;

  logic        clk, rst_n, start_i, hold_i;
  logic        busy_o, done_o, err_o, rd_en_o, sub_valid_o, sub_valid_i, wr_en_o;
  logic [7:0]  rd_addr_o, wr_addr_o;
  logic [11:0] a_rd_data_i, b_rd_data_i, sub_op1_o, sub_op2_o, sub_result_i, wr_data_o;
  logic        inject;

  poly_sub_seq #(.N_COEFF(256), .ADDR_W(8), .SUB_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_i(hold_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i),
    .sub_op1_o(sub_op1_o), .sub_op2_o(sub_op2_o), .sub_valid_o(sub_valid_o),
    .sub_result_i(sub_result_i), .sub_valid_i(sub_valid_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int addr; int data; } exp_t;
  exp_t q[$];
  int a_mem [N];
  int b_mem [N];
  int e_mem [N];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Synchronous-read A/B RAMs.
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_rd_data_i <= 12'(a_mem[rd_addr_o]);
      b_rd_data_i <= 12'(b_mem[rd_addr_o]);
    end
  end

  // Two-stage mod_sub model.
  logic        v1, v2;
  logic [11:0] r1, r2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; r1 <= '0; r2 <= '0;
    end else begin
      v1 <= sub_valid_o;
      r1 <= (sub_op1_o >= sub_op2_o) ? sub_op1_o - sub_op2_o
                                     : 12'(13'(sub_op1_o) + 13'(Q) - 13'(sub_op2_o));
      v2 <= v1;
      r2 <= r1;
    end
  end
  assign sub_valid_i  = v2 | inject;
  assign sub_result_i = r2;

  // Monitor: pop the scoreboard on every destination write.
  always @(negedge clk) begin
    if (wr_en_o) begin
      exp_t e;
      n_wr++;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0d, required no write", wr_addr_o, wr_data_o);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(wr_addr_o), e.addr);
        chk("wr_data", int'(wr_data_o), e.data);
      end
    end
  end

  // One full operation; returns on the negedge of the done cycle (or after reset abort).
  task automatic run_op(input bit hold_mode, input bit extra_starts, input int rst_at);
    int exp_done, holds, reads, n, wr0, busy_n, done_n, first_done;
    holds = 0; reads = 0; n = 0;
    while (reads < N) begin
      n++;
      if (hold_mode && (n % 17 >= 14)) holds++;
      else reads++;
    end
    exp_done = 260 + holds;
    for (int i = 0; i < N; i++) q.push_back('{addr: i, data: e_mem[i]});
    wr0 = n_wr;
    busy_n = 0; done_n = 0; first_done = 0; n = 0;
    @(negedge clk); start_i = 1'b1;
    while (1) begin
      @(negedge clk); n++;
      if (n == 1) start_i = 1'b0;
      hold_i = hold_mode && (n % 17 >= 14);
      if (extra_starts) start_i = (n == 50) || (n == exp_done);
      if (n == 1) begin
        chk("busy_cycle1", busy_o, 1);
        chk("err_cleared", err_o, 0);
      end
      if (rst_at != 0 && n == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {busy_o, done_o, err_o, rd_en_o, sub_valid_o, wr_en_o}, 0);
        chk("rst_data", {rd_addr_o, wr_addr_o, wr_data_o, sub_op1_o, sub_op2_o}, 0);
        chk("writes_before_reset", n_wr - wr0, rst_at - 3);
        q.delete();
        hold_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      busy_n += int'(busy_o);
      if (done_o) begin
        done_n++;
        if (first_done == 0) first_done = n;
      end
      if (first_done != 0 || n > exp_done + 20) break;
    end
    hold_i = 1'b0;
    chk("done_cycle", first_done, exp_done);
    chk("busy_cycles", busy_n, exp_done - 1);
    chk("write_count", n_wr - wr0, N);
    chk("queue_empty", q.size(), 0);
    chk("err_clean", err_o, 0);
    if (extra_starts) begin
      @(negedge clk); start_i = 1'b0;
      repeat (5) begin
        @(negedge clk);
        done_n += int'(done_o);
        busy_n += int'(busy_o);
      end
      chk("done_pulses", done_n, 1);
      chk("no_relaunch_busy", busy_n, exp_done - 1);
      chk("write_count_after", n_wr - wr0, N);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; hold_i = 1'b0; inject = 1'b0;
    #12;
    chk("reset_outputs", {busy_o, done_o, err_o, rd_en_o, sub_valid_o, wr_en_o}, 0);
    chk("reset_data", {rd_addr_o, wr_addr_o, wr_data_o}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: A=i, B=0 -> i.
    for (int i = 0; i < N; i++) begin a_mem[i] = i; b_mem[i] = 0; e_mem[i] = i; end
    run_op(1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Directed: A=0, B=1 -> 3328; then back-to-back A=20, B=50 -> 3299.
    for (int i = 0; i < N; i++) begin a_mem[i] = 0; b_mem[i] = 1; e_mem[i] = 3328; end
    run_op(1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) begin a_mem[i] = 20; b_mem[i] = 50; e_mem[i] = 3299; end
    run_op(1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Stray result while idle: no write, sticky error.
    inject = 1'b1;
    #1 chk("stray_no_write", wr_en_o, 0);
    @(negedge clk); inject = 1'b0;
    chk("stray_err_set", err_o, 1);
    repeat (2) @(negedge clk);
    chk("stray_err_held", err_o, 1);

    // Random operands with periodic hold bursts (start_i clears err_o).
    for (int i = 0; i < N; i++) begin
      a_mem[i] = int'($urandom_range(0, Q - 1));
      b_mem[i] = int'($urandom_range(0, Q - 1));
      e_mem[i] = (a_mem[i] + Q - b_mem[i]) % Q;
    end
    run_op(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Re-pulsed start_i at cycles 50 and 260 must be ignored: A=3328, B=i.
    for (int i = 0; i < N; i++) begin a_mem[i] = 3328; b_mem[i] = i; e_mem[i] = 3328 - i; end
    run_op(1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);

    // Reset at cycle 100, then a clean run.
    for (int i = 0; i < N; i++) begin a_mem[i] = i; b_mem[i] = 0; e_mem[i] = i; end
    run_op(1'b0, 1'b0, 100);
    repeat (2) @(negedge clk);
    chk("post_reset_idle", busy_o, 0);
    run_op(1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
